// File: rtl/cc20_pkg.sv
// ChaCha20 shared definitions: constants, FSM encoding, quarter-round tables.
// Imported by the round logic and the decrypt core.
package cc20_pkg;

    localparam logic [127:0] SIGMA = {
        32'h6b206574, 32'h79622d32,
        32'h3320646e, 32'h61707865
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_STREAM,
        S_DRAIN
    } cc20_state_e;

    // Operand slots: quarter round q uses entries 4q..4q+3 as (a,b,c,d).
    localparam logic [3:0] QR_COL [16] = '{
        4'd0, 4'd4, 4'd8,  4'd12,
        4'd1, 4'd5, 4'd9,  4'd13,
        4'd2, 4'd6, 4'd10, 4'd14,
        4'd3, 4'd7, 4'd11, 4'd15
    };

    localparam logic [3:0] QR_DIAG [16] = '{
        4'd0, 4'd5, 4'd10, 4'd15,
        4'd1, 4'd6, 4'd11, 4'd12,
        4'd2, 4'd7, 4'd8,  4'd13,
        4'd3, 4'd4, 4'd9,  4'd14
    };

    function automatic logic [31:0] rotl(
        input logic [31:0] v,
        input int          n
    );
        return (v << n) | (v >> (32 - n));
    endfunction

endpackage

// File: rtl/cc20_round.sv
// One ChaCha20 round: four quarter rounds, column or diagonal selected by diag_i.
// Purely combinational.
module cc20_round
    import cc20_pkg::*;
(
    input  logic [15:0][31:0] x_i,
    input  logic              diag_i,
    output logic [15:0][31:0] y_o
);

    logic [15:0][31:0] qi, qo;

    for (genvar q = 0; q < 4; q++) begin : g_qr
        for (genvar j = 0; j < 4; j++) begin : g_op
            assign qi[4*q+j] = diag_i ? x_i[QR_DIAG[4*q+j]]
                                      : x_i[QR_COL[4*q+j]];
        end
        chacha_qr u_qr (
            .a_i (qi[4*q]),
            .b_i (qi[4*q+1]),
            .c_i (qi[4*q+2]),
            .d_i (qi[4*q+3]),
            .a_o (qo[4*q]),
            .b_o (qo[4*q+1]),
            .c_o (qo[4*q+2]),
            .d_o (qo[4*q+3])
        );
    end

    // Word i sits in row i/4, column i%4; find its slot in each round type.
    for (genvar i = 0; i < 16; i++) begin : g_out
        localparam int CS = 4 * (i % 4) + i / 4;
        localparam int DS = 4 * (((i % 4) - (i / 4) + 4) % 4) + i / 4;
        assign y_o[i] = diag_i ? qo[DS] : qo[CS];
    end

endmodule

// File: rtl/chacha_qr.sv
// ChaCha20 quarter round on four 32-bit words.
// Purely combinational.
module chacha_qr
    import cc20_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o
);

    logic [31:0] a1, b1, c1, d1;

    assign a1  = a_i + b_i;
    assign d1  = rotl(d_i ^ a1, 16);
    assign c1  = c_i + d1;
    assign b1  = rotl(b_i ^ c1, 12);
    assign a_o = a1 + b1;
    assign d_o = rotl(d1 ^ a_o, 8);
    assign c_o = c1 + d_o;
    assign b_o = rotl(b1 ^ c_o, 7);

endmodule

// File: rtl/cc20_decrypt_core.sv
// Receive-side ChaCha20 engine: iterative block generation, keystream
// XOR onto 128-bit ciphertext beats with a registered plaintext output.
module cc20_decrypt_core
    import cc20_pkg::*;
#(
    parameter int ROUNDS = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  counter_init,
    input  logic         start,
    input  logic         ct_valid,
    output logic         ct_ready,
    input  logic [127:0] ct_data,
    input  logic         ct_last,
    output logic         pt_valid,
    input  logic         pt_ready,
    output logic [127:0] pt_data,
    output logic         pt_last,
    output logic         busy,
    output logic         ctr_wrap_err
);

    localparam int RW = $clog2(ROUNDS);

    cc20_state_e       state_q, state_d;
    logic [15:0][31:0] x_q, x_d, x_rnd, x_fin, snap;
    logic [255:0]      key_q, key_d;
    logic [95:0]       nonce_q, nonce_d;
    logic [31:0]       ctr_q, ctr_d;
    logic [RW-1:0]     rnd_q, rnd_d;
    logic [1:0]        w_q, w_d;
    logic              pv_q, pv_d, pl_q, pl_d;
    logic              err_q, err_d;
    logic [127:0]      pd_q, pd_d, ks_w;

    // Block input rebuilt from latched message regs; they hold for the block.
    assign snap = {nonce_q, ctr_q, key_q, SIGMA};
    assign ks_w = x_q[{w_q, 2'b00} +: 4];

    for (genvar i = 0; i < 16; i++) begin : g_fin
        assign x_fin[i] = x_q[i] + snap[i];
    end

    cc20_round u_round (
        .x_i    (x_q),
        .diag_i (rnd_q[0]),
        .y_o    (x_rnd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            key_q   <= '0;
            nonce_q <= '0;
            ctr_q   <= '0;
            rnd_q   <= '0;
            w_q     <= '0;
            pv_q    <= 1'b0;
            pd_q    <= '0;
            pl_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            key_q   <= key_d;
            nonce_q <= nonce_d;
            ctr_q   <= ctr_d;
            rnd_q   <= rnd_d;
            w_q     <= w_d;
            pv_q    <= pv_d;
            pd_q    <= pd_d;
            pl_q    <= pl_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        key_d    = key_q;
        nonce_d  = nonce_q;
        ctr_d    = ctr_q;
        rnd_d    = rnd_q;
        w_d      = w_q;
        pv_d     = pv_q && !pt_ready;
        pd_d     = pd_q;
        pl_d     = pl_q;
        err_d    = err_q;
        ct_ready = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d   = key;
                    nonce_d = nonce;
                    ctr_d   = counter_init;
                    err_d   = 1'b0;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                x_d     = snap;
                rnd_d   = '0;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                x_d   = x_rnd;
                rnd_d = rnd_q + 1'b1;
                if (rnd_q == RW'(ROUNDS - 1)) state_d = S_FINAL;
            end
            S_FINAL: begin
                x_d     = x_fin;
                w_d     = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                ct_ready = !pv_q || pt_ready;
                if (ct_ready && ct_valid) begin
                    pv_d = 1'b1;
                    pd_d = ct_data ^ ks_w;
                    pl_d = ct_last;
                    w_d  = w_q + 1'b1;
                    if (ct_last) begin
                        state_d = S_DRAIN;
                    end else if (w_q == 2'd3) begin
                        if (ctr_q == '1) begin
                            err_d   = 1'b1;
                            state_d = S_DRAIN;
                        end else begin
                            ctr_d   = ctr_q + 1'b1;
                            state_d = S_INIT;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (!pv_q || pt_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pt_valid     = pv_q;
    assign pt_data      = pd_q;
    assign pt_last      = pl_q;
    assign busy         = (state_q != S_IDLE);
    assign ctr_wrap_err = err_q;

endmodule

// File: tb/tb_cc20_decrypt_core.sv
// Bench for cc20_decrypt_core: RFC 8439 vectors plus randomized messages
// checked against an array-based ChaCha20 block model.
module tb_cc20_decrypt_core;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  counter_init;
    logic         start;
    logic         ct_valid;
    logic         ct_ready;
    logic [127:0] ct_data;
    logic         ct_last;
    logic         pt_valid;
    logic         pt_ready;
    logic [127:0] pt_data;
    logic         pt_last;
    logic         busy;
    logic         ctr_wrap_err;

    int total = 0;
    int bad   = 0;

    logic [128:0] out_q[$];

    localparam logic [95:0] N232 = 96'h00000000_4a000000_09000000;
    localparam logic [95:0] N242 = 96'h00000000_4a000000_00000000;

    cc20_decrypt_core dut (
        .clk          (clk),
        .reset        (reset),
        .key          (key),
        .nonce        (nonce),
        .counter_init (counter_init),
        .start        (start),
        .ct_valid     (ct_valid),
        .ct_ready     (ct_ready),
        .ct_data      (ct_data),
        .ct_last      (ct_last),
        .pt_valid     (pt_valid),
        .pt_ready     (pt_ready),
        .pt_data      (pt_data),
        .pt_last      (pt_last),
        .busy         (busy),
        .ctr_wrap_err (ctr_wrap_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (reset && pt_valid && pt_ready)
            out_q.push_back({pt_last, pt_data});

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [127:0] qr(input logic [31:0] a_in,
                                        input logic [31:0] b_in,
                                        input logic [31:0] c_in,
                                        input logic [31:0] d_in);
        logic [31:0] a, b, c, d;
        a = a_in; b = b_in; c = c_in; d = d_in;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {d, c, b, a};
    endfunction

    function automatic logic [511:0] ref_block(input logic [255:0] k,
                                               input logic [95:0]  n,
                                               input logic [31:0]  c);
        logic [31:0]  s[16];
        logic [31:0]  x[16];
        logic [511:0] r;
        s[0] = 32'h61707865; s[1] = 32'h3320646e;
        s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
        s[12] = c;
        for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
        x = s;
        for (int dr = 0; dr < 10; dr++) begin
            {x[12], x[8],  x[4], x[0]} = qr(x[0], x[4], x[8],  x[12]);
            {x[13], x[9],  x[5], x[1]} = qr(x[1], x[5], x[9],  x[13]);
            {x[14], x[10], x[6], x[2]} = qr(x[2], x[6], x[10], x[14]);
            {x[15], x[11], x[7], x[3]} = qr(x[3], x[7], x[11], x[15]);
            {x[15], x[10], x[5], x[0]} = qr(x[0], x[5], x[10], x[15]);
            {x[12], x[11], x[6], x[1]} = qr(x[1], x[6], x[11], x[12]);
            {x[13], x[8],  x[7], x[2]} = qr(x[2], x[7], x[8],  x[13]);
            {x[14], x[9],  x[4], x[3]} = qr(x[3], x[4], x[9],  x[14]);
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
        return r;
    endfunction

    function automatic logic [127:0] ref_beat(input logic [255:0] k,
                                              input logic [95:0]  n,
                                              input logic [31:0]  c,
                                              input int           j);
        logic [511:0] b;
        b = ref_block(k, n, c + 32'(j / 4));
        return b[128*(j % 4) +: 128];
    endfunction

    function automatic logic [255:0] rfc_key();
        logic [255:0] k;
        for (int i = 0; i < 32; i++) k[8*i +: 8] = 8'(i);
        return k;
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    function automatic logic [127:0] rand_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_start(input logic [255:0] k, input logic [95:0] n,
                            input logic [31:0] c);
        key = k; nonce = n; counter_init = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input logic [127:0] cts[$], input int gap,
                        input int bp, input int budget, output int acc);
        acc = 0;
        for (int t = 0; t < budget && acc < cts.size(); t++) begin
            ct_valid = ($urandom_range(99) >= gap);
            ct_data  = cts[acc];
            ct_last  = (acc == cts.size() - 1);
            pt_ready = ($urandom_range(99) >= bp);
            @(negedge clk);
            if (ct_valid && ct_ready) acc++;
            @(posedge clk); #1;
        end
        ct_valid = 1'b0; ct_last = 1'b0; pt_ready = 1'b1;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 200 && busy; t++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; ct_valid = 1'b0; ct_data = '0;
        ct_last = 1'b0; pt_ready = 1'b0; key = '0; nonce = '0;
        counter_init = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (ct_ready !== 1'b0) begin bad++; $display("FAIL reset ct_ready: got %b want 0", ct_ready); end
        total++; if (pt_valid !== 1'b0) begin bad++; $display("FAIL reset pt_valid: got %b want 0", pt_valid); end
        total++; if (pt_data !== '0) begin bad++; $display("FAIL reset pt_data: got %h want 0", pt_data); end
        total++; if (pt_last !== 1'b0) begin bad++; $display("FAIL reset pt_last: got %b want 0", pt_last); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
        total++; if (ctr_wrap_err !== 1'b0) begin bad++; $display("FAIL reset err: got %b want 0", ctr_wrap_err); end
        reset = 1'b1; pt_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle busy: got %b want 0", busy); end
    endtask

    task automatic test_rfc_block();
        logic [127:0] exp;
        int n;
        out_q.delete();
        do_start(rfc_key(), N232, 32'd1);
        n = 0;
        while (!ct_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        total++; if (n !== 22) begin bad++; $display("FAIL latency: got %0d want 22", n); end
        ct_valid = 1'b1; ct_data = '0; ct_last = 1'b1; pt_ready = 1'b1;
        @(posedge clk); #1;
        ct_valid = 1'b0; ct_last = 1'b0;
        exp = ref_beat(rfc_key(), N232, 32'd1, 0);
        total++; if (pt_valid !== 1'b1) begin bad++; $display("FAIL rfc pt_valid: got %b want 1", pt_valid); end
        total++; if (pt_data[31:0] !== 32'he4e7f110) begin bad++; $display("FAIL rfc w0: got %h want e4e7f110", pt_data[31:0]); end
        total++; if (pt_data[63:32] !== 32'h15593bd1) begin bad++; $display("FAIL rfc w1: got %h want 15593bd1", pt_data[63:32]); end
        total++; if (pt_data !== exp) begin bad++; $display("FAIL rfc beat: got %h want %h", pt_data, exp); end
        total++; if (pt_last !== 1'b1) begin bad++; $display("FAIL rfc pt_last: got %b want 1", pt_last); end
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rfc busy: got %b want 0", busy); end
        total++; if (pt_valid !== 1'b0) begin bad++; $display("FAIL rfc drained: got %b want 0", pt_valid); end
        out_q.delete();
    endtask

    task automatic test_rfc_message();
        string msg;
        logic [127:0] cts[$];
        logic [127:0] pts[$];
        logic [127:0] pb;
        logic [128:0] exp;
        int nb, acc;
        msg = {"Ladies and Gentlemen of the class of '99: If I could ",
               "offer you only one tip for the future, sunscreen would be it."};
        nb = (msg.len() + 15) / 16;
        for (int j = 0; j < nb; j++) begin
            pb = '0;
            for (int i = 0; i < 16; i++)
                if (16*j + i < msg.len()) pb[8*i +: 8] = msg[16*j + i];
            pts.push_back(pb);
            cts.push_back(pb ^ ref_beat(rfc_key(), N242, 32'd1, j));
        end
        out_q.delete();
        do_start(rfc_key(), N242, 32'd1);
        feed(cts, 20, 30, 2000, acc);
        wait_idle();
        total++; if (acc !== nb) begin bad++; $display("FAIL msg accepted: got %0d want %0d", acc, nb); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL msg busy: got %b want 0", busy); end
        total++; if (out_q.size() !== nb) begin bad++; $display("FAIL msg beats: got %0d want %0d", out_q.size(), nb); end
        for (int j = 0; j < nb && j < out_q.size(); j++) begin
            exp = {(j == nb - 1), pts[j]};
            total++; if (out_q[j] !== exp) begin bad++; $display("FAIL msg beat%0d: got %h want %h", j, out_q[j], exp); end
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] k;
        logic [95:0] n;
        logic [31:0] c;
        logic [127:0] cts[$];
        logic [127:0] rest[$];
        logic [127:0] held;
        logic [128:0] exp;
        int acc, t;
        k = rand_key(); n = {$urandom, $urandom, $urandom};
        c = $urandom_range(32'h7fffffff);
        for (int j = 0; j < 8; j++) cts.push_back(rand_beat());
        out_q.delete();
        do_start(k, n, c);
        pt_ready = 1'b1;
        t = 0;
        while (!ct_ready && t < 100) begin
            @(posedge clk); #1; t++;
        end
        total++; if (ct_ready !== 1'b1) begin bad++; $display("FAIL bp ready: got %b want 1", ct_ready); end
        for (int j = 0; j < 2; j++) begin
            ct_valid = 1'b1; ct_data = cts[j]; ct_last = 1'b0;
            @(posedge clk); #1;
        end
        pt_ready = 1'b0; ct_data = cts[2];
        held = pt_data;
        exp = {1'b0, cts[1] ^ ref_beat(k, n, c, 1)};
        total++; if ({pt_last, held} !== exp) begin bad++; $display("FAIL bp held: got %h want %h", {pt_last, held}, exp); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (ct_ready !== 1'b0) begin bad++; $display("FAIL bp ct_ready%0d: got %b want 0", i, ct_ready); end
            total++; if (pt_valid !== 1'b1) begin bad++; $display("FAIL bp pt_valid%0d: got %b want 1", i, pt_valid); end
            total++; if (pt_data !== held) begin bad++; $display("FAIL bp stable%0d: got %h want %h", i, pt_data, held); end
            @(posedge clk); #1;
        end
        for (int j = 2; j < 8; j++) rest.push_back(cts[j]);
        feed(rest, 0, 0, 200, acc);
        wait_idle();
        total++; if (acc !== 6) begin bad++; $display("FAIL bp accepted: got %0d want 6", acc); end
        total++; if (out_q.size() !== 8) begin bad++; $display("FAIL bp beats: got %0d want 8", out_q.size()); end
        for (int j = 0; j < 8 && j < out_q.size(); j++) begin
            exp = {(j == 7), cts[j] ^ ref_beat(k, n, c, j)};
            total++; if (out_q[j] !== exp) begin bad++; $display("FAIL bp beat%0d: got %h want %h", j, out_q[j], exp); end
        end
    endtask

    task automatic test_ctr_wrap();
        logic [255:0] k;
        logic [95:0] n;
        logic [127:0] cts[$];
        logic [128:0] exp;
        int acc;
        k = rand_key(); n = {$urandom, $urandom, $urandom};
        for (int j = 0; j < 5; j++) cts.push_back(rand_beat());
        out_q.delete();
        do_start(k, n, 32'hffffffff);
        feed(cts, 0, 0, 150, acc);
        wait_idle();
        total++; if (acc !== 4) begin bad++; $display("FAIL wrap accepted: got %0d want 4", acc); end
        total++; if (ctr_wrap_err !== 1'b1) begin bad++; $display("FAIL wrap err: got %b want 1", ctr_wrap_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrap busy: got %b want 0", busy); end
        total++; if (out_q.size() !== 4) begin bad++; $display("FAIL wrap beats: got %0d want 4", out_q.size()); end
        for (int j = 0; j < 4 && j < out_q.size(); j++) begin
            exp = {1'b0, cts[j] ^ ref_beat(k, n, 32'hffffffff, j)};
            total++; if (out_q[j] !== exp) begin bad++; $display("FAIL wrap beat%0d: got %h want %h", j, out_q[j], exp); end
        end
    endtask

    task automatic test_reset_mid();
        logic [128:0] exp;
        int acc;
        logic [127:0] cts[$];
        total++; if (ctr_wrap_err !== 1'b1) begin bad++; $display("FAIL sticky err: got %b want 1", ctr_wrap_err); end
        do_start(rfc_key(), N232, 32'd1);
        total++; if (ctr_wrap_err !== 1'b0) begin bad++; $display("FAIL err clear: got %b want 0", ctr_wrap_err); end
        repeat (10) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid busy: got %b want 1", busy); end
        reset = 1'b0;
        #1;
        total++; if ({busy, ct_ready, pt_valid, pt_last, ctr_wrap_err} !== 5'b0) begin bad++; $display("FAIL mid reset flags: got %b want 00000", {busy, ct_ready, pt_valid, pt_last, ctr_wrap_err}); end
        total++; if (pt_data !== '0) begin bad++; $display("FAIL mid reset data: got %h want 0", pt_data); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        out_q.delete();
        cts.push_back('0);
        do_start(rfc_key(), N232, 32'd1);
        feed(cts, 0, 0, 100, acc);
        wait_idle();
        exp = {1'b1, ref_beat(rfc_key(), N232, 32'd1, 0)};
        total++; if (out_q.size() !== 1) begin bad++; $display("FAIL restart beats: got %0d want 1", out_q.size()); end
        if (out_q.size() > 0) begin
            total++; if (out_q[0] !== exp) begin bad++; $display("FAIL restart beat: got %h want %h", out_q[0], exp); end
            total++; if (out_q[0][31:0] !== 32'he4e7f110) begin bad++; $display("FAIL restart w0: got %h want e4e7f110", out_q[0][31:0]); end
        end
    endtask

    task automatic test_busy_start();
        logic [255:0] k1;
        logic [95:0] n1;
        logic [31:0] c1;
        logic [127:0] cts[$];
        logic [128:0] exp;
        int acc;
        k1 = rand_key(); n1 = {$urandom, $urandom, $urandom};
        c1 = $urandom_range(32'h7fffffff);
        for (int j = 0; j < 6; j++) cts.push_back(rand_beat());
        out_q.delete();
        do_start(k1, n1, c1);
        repeat (3) @(posedge clk);
        #1;
        key = rand_key(); nonce = ~n1; counter_init = c1 + 32'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ign busy: got %b want 1", busy); end
        feed(cts, 10, 20, 1000, acc);
        wait_idle();
        total++; if (acc !== 6) begin bad++; $display("FAIL ign accepted: got %0d want 6", acc); end
        total++; if (out_q.size() !== 6) begin bad++; $display("FAIL ign beats: got %0d want 6", out_q.size()); end
        for (int j = 0; j < 6 && j < out_q.size(); j++) begin
            exp = {(j == 5), cts[j] ^ ref_beat(k1, n1, c1, j)};
            total++; if (out_q[j] !== exp) begin bad++; $display("FAIL ign beat%0d: got %h want %h", j, out_q[j], exp); end
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] k;
        logic [95:0] n;
        logic [31:0] c;
        logic [127:0] cts[$];
        logic [128:0] exp;
        int nb, acc;
        for (int m = 0; m < 4; m++) begin
            k = rand_key(); n = {$urandom, $urandom, $urandom};
            c = $urandom_range(32'hfffffff0);
            nb = $urandom_range(9, 1);
            cts.delete();
            for (int j = 0; j < nb; j++) cts.push_back(rand_beat());
            out_q.delete();
            do_start(k, n, c);
            feed(cts, $urandom_range(40), $urandom_range(50), 2000, acc);
            wait_idle();
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b%0d busy: got %b want 0", m, busy); end
            total++; if (out_q.size() !== nb) begin bad++; $display("FAIL b2b%0d beats: got %0d want %0d", m, out_q.size(), nb); end
            for (int j = 0; j < nb && j < out_q.size(); j++) begin
                exp = {(j == nb - 1), cts[j] ^ ref_beat(k, n, c, j)};
                total++; if (out_q[j] !== exp) begin bad++; $display("FAIL b2b%0d beat%0d: got %h want %h", m, j, out_q[j], exp); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rfc_block();
        test_rfc_message();
        test_backpressure();
        test_ctr_wrap();
        test_reset_mid();
        test_busy_start();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
